// File: rtl/ram_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter_pkg
// Shared definitions for the SPC700 / host RAM port arbiter:
//   - arb_state_e : arbiter FSM state encoding (3 bits)
//   - helper functions decoding which side owns the RAM in a given state
// No ports (package).
// ----------------------------------------------------------------------------
package ram_port_arbiter_pkg;

  localparam int ARB_STATE_W = 3;

  typedef enum logic [ARB_STATE_W-1:0] {
    ST_CPU   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_HOST  = 3'd2,
    ST_ACK   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_FAIR  = 3'd5
  } arb_state_e;

  // RAM address/data path is switched to the host port in these states.
  function automatic logic mux_to_host(input arb_state_e state);
    return (state == ST_HOST) || (state == ST_ACK) || (state == ST_WAIT);
  endfunction

  // Reported ownership also covers the drain cycle: the CPU is already paused.
  function automatic logic host_owns(input arb_state_e state);
    return (state == ST_DRAIN) || mux_to_host(state);
  endfunction

  // States in which the CPU may execute (subject to in_cpu_enable).
  function automatic logic cpu_slot(input arb_state_e state);
    return (state == ST_CPU) || (state == ST_FAIR);
  endfunction

endpackage

// File: rtl/ram_port_mux.sv
// ----------------------------------------------------------------------------
// ram_port_mux
// Combinational 2:1 select of the RAM address / write data / write enable
// between the CPU bus and the host port, with a write-enable gate.
// Ports:
//   i_sel_host      1 = drive RAM from host port, 0 = from CPU bus
//   i_we_gate       write permission for the selected side
//   i_cpu_*         CPU address, write data, write strobe
//   i_host_*        host address, write data, write strobe
//   o_ram_*         RAM address, write data, write enable
// ----------------------------------------------------------------------------
module ram_port_mux #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_sel_host,
  input  logic                  i_we_gate,
  input  logic [ADDR_WIDTH-1:0] i_cpu_address,
  input  logic [DATA_WIDTH-1:0] i_cpu_write,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_host_address,
  input  logic [DATA_WIDTH-1:0] i_host_write,
  input  logic                  i_host_we,
  output logic [ADDR_WIDTH-1:0] o_ram_address,
  output logic [DATA_WIDTH-1:0] o_ram_write,
  output logic                  o_ram_we
);

  // Select the RAM driver; the gate can only remove a write, never create one.
  always_comb begin
    o_ram_address = i_cpu_address;
    o_ram_write   = i_cpu_write;
    o_ram_we      = 1'b0;
    if (i_sel_host) begin
      o_ram_address = i_host_address;
      o_ram_write   = i_host_write;
      o_ram_we      = i_host_we & i_we_gate;
    end else begin
      o_ram_address = i_cpu_address;
      o_ram_write   = i_cpu_write;
      o_ram_we      = i_cpu_we & i_we_gate;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter
// Shares the single-port system RAM between the SPC700 CPU and a host/test
// port. The CPU is paused through a registered clock-enable while the host
// performs one access per HOST/ACK/WAIT round; after MAX_HOST_BURST host
// accesses the CPU is given a forced slot of CPU_SLOT_CYCLES cycles.
// Ports:
//   clock, reset               rising-edge clock, async active-low reset
//   in_cpu_enable              1 = CPU may run, 0 = host-only mode
//   in_cpu_address/write/..    CPU bus (address, write data, write strobe)
//   out_cpu_run                CPU clock-enable (registered)
//   in_host_req/we/address/..  host request (level), direction, address, data
//   out_host_ack               one-cycle completion pulse (registered)
//   out_host_read              read data, held from ack until next host access
//   out_host_owns              RAM belongs to host (DRAIN..WAIT)
//   out_ram_*, in_ram_read     RAM interface
// ----------------------------------------------------------------------------
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_HOST_BURST  = 16,
  parameter int CPU_SLOT_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_cpu_enable,
  input  logic [ADDR_WIDTH-1:0] in_cpu_address,
  input  logic [DATA_WIDTH-1:0] in_cpu_write,
  input  logic                  in_cpu_write_enable,
  output logic                  out_cpu_run,
  input  logic                  in_host_req,
  input  logic                  in_host_we,
  input  logic [ADDR_WIDTH-1:0] in_host_address,
  input  logic [DATA_WIDTH-1:0] in_host_write,
  output logic                  out_host_ack,
  output logic [DATA_WIDTH-1:0] out_host_read,
  output logic                  out_host_owns,
  output logic [ADDR_WIDTH-1:0] out_ram_address,
  output logic [DATA_WIDTH-1:0] out_ram_write,
  output logic                  out_ram_write_enable,
  input  logic [DATA_WIDTH-1:0] in_ram_read
);

  localparam int BURST_W = $clog2(MAX_HOST_BURST + 1);
  localparam int SLOT_W  = $clog2(CPU_SLOT_CYCLES + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_HOST_BURST);
  localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(CPU_SLOT_CYCLES - 1);

  arb_state_e                r_state;
  arb_state_e                w_next_state;
  logic [BURST_W-1:0]        r_burst_cnt;
  logic [SLOT_W-1:0]         r_slot_cnt;
  logic                      r_cpu_run;
  logic                      r_host_ack;
  logic                      r_host_owns;
  logic [DATA_WIDTH-1:0]     r_host_read;
  logic                      w_slot_done;
  logic                      w_sel_host;
  logic                      w_we_gate;

  assign w_slot_done = (r_slot_cnt == SLOT_LAST);
  assign w_sel_host  = mux_to_host(r_state);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_CPU;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_CPU: begin
        // A CPU that ran this cycle (even if enable is just falling) may have
        // a write in flight, so it gets one write-free drain cycle first.
        if (in_host_req) begin
          if (in_cpu_enable || r_cpu_run) begin
            w_next_state = ST_DRAIN;
          end else begin
            w_next_state = ST_HOST;
          end
        end else begin
          w_next_state = ST_CPU;
        end
      end
      ST_DRAIN: w_next_state = ST_HOST;
      ST_HOST:  w_next_state = ST_ACK;
      ST_ACK:   w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (!in_host_req) begin
          w_next_state = ST_CPU;
        end else if (in_cpu_enable && (r_burst_cnt >= BURST_MAX)) begin
          w_next_state = ST_FAIR;
        end else begin
          w_next_state = ST_HOST;
        end
      end
      ST_FAIR: begin
        if (!in_cpu_enable) begin
          w_next_state = in_host_req ? ST_HOST : ST_CPU;
        end else if (w_slot_done) begin
          w_next_state = in_host_req ? ST_DRAIN : ST_CPU;
        end else begin
          w_next_state = ST_FAIR;
        end
      end
      default: w_next_state = ST_CPU;
    endcase
  end

  // Write permission for whichever side the mux currently selects.
  always_comb begin
    w_we_gate = 1'b0;
    case (r_state)
      ST_CPU:   w_we_gate = r_cpu_run;
      ST_FAIR:  w_we_gate = r_cpu_run;
      ST_HOST:  w_we_gate = 1'b1;
      default:  w_we_gate = 1'b0;
    endcase
  end

  // Registered status outputs derived from the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cpu_run   <= 1'b0;
      r_host_ack  <= 1'b0;
      r_host_owns <= 1'b0;
    end else begin
      r_cpu_run   <= in_cpu_enable & cpu_slot(w_next_state);
      r_host_ack  <= (w_next_state == ST_ACK);
      r_host_owns <= host_owns(w_next_state);
    end
  end

  // Host read data captured at the end of the HOST cycle, held otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_host_read <= {DATA_WIDTH{1'b0}};
    end else if ((r_state == ST_HOST) && !in_host_we) begin
      r_host_read <= in_ram_read;
    end else begin
      r_host_read <= r_host_read;
    end
  end

  // Saturating count of host accesses since the CPU last had the RAM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_burst_cnt <= {BURST_W{1'b0}};
    end else if (cpu_slot(w_next_state)) begin
      r_burst_cnt <= {BURST_W{1'b0}};
    end else if ((r_state == ST_HOST) && (r_burst_cnt != BURST_MAX)) begin
      r_burst_cnt <= r_burst_cnt + BURST_W'(1);
    end else begin
      r_burst_cnt <= r_burst_cnt;
    end
  end

  // Forced CPU slot timer: zero on entry, counts while the slot continues.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_slot_cnt <= {SLOT_W{1'b0}};
    end else if ((w_next_state == ST_FAIR) && (r_state != ST_FAIR)) begin
      r_slot_cnt <= {SLOT_W{1'b0}};
    end else if ((w_next_state == ST_FAIR) && (r_state == ST_FAIR)) begin
      r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
    end else begin
      r_slot_cnt <= r_slot_cnt;
    end
  end

  ram_port_mux #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux (
    .i_sel_host     (w_sel_host),
    .i_we_gate      (w_we_gate),
    .i_cpu_address  (in_cpu_address),
    .i_cpu_write    (in_cpu_write),
    .i_cpu_we       (in_cpu_write_enable),
    .i_host_address (in_host_address),
    .i_host_write   (in_host_write),
    .i_host_we      (in_host_we),
    .o_ram_address  (out_ram_address),
    .o_ram_write    (out_ram_write),
    .o_ram_we       (out_ram_write_enable)
  );

  assign out_cpu_run   = r_cpu_run;
  assign out_host_ack  = r_host_ack;
  assign out_host_owns = r_host_owns;
  assign out_host_read = r_host_read;

endmodule
